// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - prioritized stall/flush sequencer with MEM wait FSM; PIPE_STALL_PERF_EN adds perf counters
module pipe_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_hazard_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_mem_stall;
  logic              w_freeze;

  assign w_mem_stall = dmem_req_i && !dmem_ready_i;
  // ERROR holds the whole pipeline; otherwise only an unfinished access freezes it
  assign w_freeze    = (r_state == ST_ERROR) || w_mem_stall;

  // State register and MEM_WAIT cycle counter (cleared outside MEM_WAIT, saturating inside)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state != ST_MEM_WAIT) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  // Next state: the cycle that completes the MEM_TIMEOUT-th wait without ready enters ERROR
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) w_next_state = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (dmem_ready_i)              w_next_state = ST_RUN;
        else if (r_wait_cnt == WAIT_LAST) w_next_state = ST_ERROR;
      end
      ST_ERROR: w_next_state = ST_ERROR;
      default:  w_next_state = ST_RUN;
    endcase
  end

  // Output decode: reset, then freeze, then branch, then load-use, then normal flow
  always_comb begin
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b1;
    id_ex_bubble_o  = 1'b0;
    ex_mem_write_o  = 1'b1;
    mem_wb_bubble_o = 1'b0;
    mem_timeout_o   = 1'b0;
    if (rst_i) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_write_o   = 1'b0;
      id_ex_bubble_o  = 1'b1;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (w_freeze) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_write_o   = 1'b0;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
      mem_timeout_o   = (r_state == ST_ERROR);
    end else if (branch_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (load_use_hazard_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_flush_win;

  assign w_flush_win = !w_freeze && branch_taken_i;

  // Performance counters: stalled-PC cycles and winning branch flushes, wrapping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write_o) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_win) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and randomized checks of pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 8;
`ifdef PIPE_STALL_PERF_EN
  localparam int PERF  = 1;
`else
  localparam int PERF  = 0;
`endif

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_timeout}
  localparam logic [7:0] C_RST    = 8'b0010_1010;
  localparam logic [7:0] C_FREEZE = 8'b0000_0010;
  localparam logic [7:0] C_ERROR  = 8'b0000_0011;
  localparam logic [7:0] C_BRANCH = 8'b1111_1100;
  localparam logic [7:0] C_LU     = 8'b0001_1100;
  localparam logic [7:0] C_NORMAL = 8'b1101_0100;

  logic clk = 1'b0;
  logic rst_i = 1'b1, lu_i = 1'b0, br_i = 1'b0, req_i = 1'b0, rdy_i = 1'b0;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, tmo;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [7:0] w_ctl;

  int n_vec = 0;
  int n_err = 0;

  // model state: m_wait < 0 means no outstanding memory wait
  int m_wait  = -1;
  bit m_err   = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  assign w_ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, tmo};

  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .load_use_hazard_i(lu_i),
    .branch_taken_i   (br_i),
    .dmem_req_i       (req_i),
    .dmem_ready_i     (rdy_i),
    .pc_write_o       (pc_w),
    .if_id_write_o    (ifid_w),
    .if_id_flush_o    (ifid_f),
    .id_ex_write_o    (idex_w),
    .id_ex_bubble_o   (idex_b),
    .ex_mem_write_o   (exmem_w),
    .mem_wb_bubble_o  (memwb_b),
    .mem_timeout_o    (tmo),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  function automatic bit m_freeze();
    return m_err || (req_i && !rdy_i);
  endfunction

  function automatic logic [7:0] m_ctl();
    if (rst_i)      return C_RST;
    if (m_err)      return C_ERROR;
    if (m_freeze()) return C_FREEZE;
    if (br_i)       return C_BRANCH;
    if (lu_i)       return C_LU;
    return C_NORMAL;
  endfunction

  function automatic logic [CW-1:0] m_stall_exp();
    return PERF ? CW'(m_stall) : '0;
  endfunction

  function automatic logic [CW-1:0] m_flush_exp();
    return PERF ? CW'(m_flush) : '0;
  endfunction

  // advance the model by one clock using the inputs the DUT sampled on this edge
  task automatic advance();
    logic [7:0] e;
    e = m_ctl();
    if (rst_i) begin
      m_wait = -1; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[7]) m_stall = (m_stall + 1) % (1 << CW);
      if (!m_freeze() && br_i) m_flush = (m_flush + 1) % (1 << CW);
      if (!m_err) begin
        if (m_wait < 0) begin
          if (req_i && !rdy_i) m_wait = 0;
        end else if (rdy_i) begin
          m_wait = -1;
        end else if (m_wait + 1 >= TO) begin
          m_err = 1'b1;
        end else begin
          m_wait++;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit lu, input bit br, input bit rq, input bit rd);
    @(posedge clk);
    advance();
    #1;
    rst_i = r; lu_i = lu; br_i = br; req_i = rq; rdy_i = rd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 0);
    n_vec++; if (w_ctl !== C_RST) begin n_err++; $display("FAIL reset_ctl got %b want %b", w_ctl, C_RST); end
    n_vec++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    n_vec++; if (w_ctl !== C_LU) begin n_err++; $display("FAIL load_use_ctl got %b want %b", w_ctl, C_LU); end
    drive(0, 0, 0, 0, 0);
    n_vec++; if (w_ctl !== C_NORMAL) begin n_err++; $display("FAIL load_use_after got %b want %b", w_ctl, C_NORMAL); end
    n_vec++; if (stall_cnt !== CW'(PERF)) begin n_err++; $display("FAIL load_use_cnt got %0d want %0d", stall_cnt, PERF); end
  endtask

  task automatic test_branch_load_use();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    n_vec++; if (w_ctl !== C_BRANCH) begin n_err++; $display("FAIL branch_lu_ctl got %b want %b", w_ctl, C_BRANCH); end
    drive(0, 0, 0, 0, 0);
    n_vec++; if (flush_cnt !== CW'(PERF) || stall_cnt !== '0) begin n_err++; $display("FAIL branch_lu_cnt got %0d/%0d want %0d/0", flush_cnt, stall_cnt, PERF); end
  endtask

  task automatic test_mem_wait();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 0);
      n_vec++; if (w_ctl !== C_FREEZE) begin n_err++; $display("FAIL mem_wait_freeze%0d got %b want %b", i, w_ctl, C_FREEZE); end
    end
    drive(0, 1, 1, 1, 1);
    n_vec++; if (w_ctl !== C_BRANCH) begin n_err++; $display("FAIL mem_wait_release got %b want %b", w_ctl, C_BRANCH); end
    drive(0, 0, 0, 0, 0);
    n_vec++; if (stall_cnt !== CW'(3 * PERF) || flush_cnt !== CW'(PERF)) begin n_err++; $display("FAIL mem_wait_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, 3 * PERF, PERF); end
    // longest legal wait: entry cycle plus TO-1 MEM_WAIT cycles, released on the TO-th
    for (int i = 0; i < TO; i++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    n_vec++; if (w_ctl !== C_NORMAL) begin n_err++; $display("FAIL mem_wait_edge got %b want %b", w_ctl, C_NORMAL); end
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i <= TO; i++) begin
      drive(0, 0, 0, 1, 0);
      n_vec++; if (w_ctl !== C_FREEZE) begin n_err++; $display("FAIL timeout_wait%0d got %b want %b", i, w_ctl, C_FREEZE); end
    end
    drive(0, 0, 0, 1, 1);
    n_vec++; if (w_ctl !== C_ERROR) begin n_err++; $display("FAIL timeout_error got %b want %b", w_ctl, C_ERROR); end
    drive(0, 1, 1, 0, 0);
    n_vec++; if (w_ctl !== C_ERROR) begin n_err++; $display("FAIL timeout_sticky got %b want %b", w_ctl, C_ERROR); end
    drive(1, 0, 0, 0, 0);
    n_vec++; if (w_ctl !== C_RST) begin n_err++; $display("FAIL timeout_rst got %b want %b", w_ctl, C_RST); end
    drive(0, 0, 0, 0, 0);
    n_vec++; if (w_ctl !== C_NORMAL) begin n_err++; $display("FAIL timeout_recover got %b want %b", w_ctl, C_NORMAL); end
  endtask

  task automatic test_reset_mid_wait();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    drive(1, 1, 1, 1, 0);
    n_vec++; if (w_ctl !== C_RST) begin n_err++; $display("FAIL midwait_rst got %b want %b", w_ctl, C_RST); end
    drive(0, 0, 0, 0, 0);
    n_vec++; if (w_ctl !== C_NORMAL) begin n_err++; $display("FAIL midwait_after got %b want %b", w_ctl, C_NORMAL); end
    n_vec++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_err++; $display("FAIL midwait_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    for (int i = 0; i < TO; i++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    n_vec++; if (w_ctl !== C_NORMAL) begin n_err++; $display("FAIL midwait_fresh got %b want %b", w_ctl, C_NORMAL); end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      e = m_ctl();
      n_vec++; if (w_ctl !== e) begin n_err++; $display("FAIL rand_ctl cyc %0d got %b want %b", i, w_ctl, e); end
      n_vec++; if (stall_cnt !== m_stall_exp() || flush_cnt !== m_flush_exp()) begin
        n_err++; $display("FAIL rand_cnt cyc %0d got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall_exp(), m_flush_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
